// File: rtl/pipe_reg_fd_pkg.sv
// Shared constants for the fetch/decode pipeline register: exception codes,
// the bubble instruction and default instruction-memory geometry.
package pipe_reg_fd_pkg;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
  localparam int          IM_WORDS_DEFAULT = 1024;

endpackage

// File: rtl/pipe_reg_fd_addr_check.sv
// Combinational fetch-address check: flags misaligned PCs and PCs outside the
// instruction memory window [IM_BASE, IM_BASE + 4*IM_WORDS).
module fd_addr_check #(
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic [31:0] pc,
  output logic        fault
);

  // 33-bit upper bound so a window ending at the top of memory cannot wrap to a small value
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic misaligned;
  logic below;
  logic above;

  assign misaligned = (pc[1:0] != 2'b00);
  assign below      = (pc < IM_BASE);
  assign above      = ({1'b0, pc} >= IM_LIMIT);
  assign fault      = misaligned | below | above;

endmodule

// File: rtl/pipe_reg_fd.sv
// F/D pipeline register with stall/flush, delay-slot flag and fetch AdEL detection.
// Optional stall/bubble performance counters under PIPE_FD_PERF_EN.
module pipe_reg_fd
  import pipe_reg_fd_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic        Branch_D,
  input  logic [31:0] IR_F,
  input  logic [31:0] PC_F,
  input  logic [31:0] PC4_F,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic [31:0] PC8_D,
  output logic        Valid_D,
  output logic        BD_D,
  output logic [4:0]  ExcCode_D,
  output logic [31:0] StallCnt,
  output logic [31:0] BubbleCnt
);

  logic fetch_fault;

  fd_addr_check #(
    .IM_BASE  (IM_BASE),
    .IM_WORDS (IM_WORDS)
  ) u_addr_check (
    .pc    (PC_F),
    .fault (fetch_fault)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      IR_D      <= INSTR_NOP;
      PC_D      <= IM_BASE;
      PC4_D     <= IM_BASE + 32'd4;
      PC8_D     <= IM_BASE + 32'd8;
      Valid_D   <= 1'b0;
      BD_D      <= 1'b0;
      ExcCode_D <= EXC_NONE;
    end else if (Flush_D) begin
      // bubble still carries the fetch PC so EPC/link logic sees a sane address
      IR_D      <= INSTR_NOP;
      PC_D      <= PC_F;
      PC4_D     <= PC4_F;
      PC8_D     <= PC4_F + 32'd4;
      Valid_D   <= 1'b0;
      BD_D      <= 1'b0;
      ExcCode_D <= EXC_NONE;
    end else if (!Stall_D) begin
      IR_D      <= fetch_fault ? INSTR_NOP : IR_F;
      PC_D      <= PC_F;
      PC4_D     <= PC4_F;
      PC8_D     <= PC4_F + 32'd4;
      Valid_D   <= 1'b1;
      BD_D      <= Branch_D & Valid_D;
      ExcCode_D <= fetch_fault ? EXC_ADEL : EXC_NONE;
    end
  end

`ifdef PIPE_FD_PERF_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      StallCnt  <= 32'd0;
      BubbleCnt <= 32'd0;
    end else begin
      if (Stall_D && !Flush_D) StallCnt <= StallCnt + 32'd1;
      if (Flush_D)             BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`else
  assign StallCnt  = 32'd0;
  assign BubbleCnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_reg_fd.sv
// Directed, table-driven bench for pipe_reg_fd: load, delay slot, stall, flush,
// fetch-address faults and reset priority, with hand-computed expectations.
module tb_pipe_reg_fd;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        Stall_D = 1'b0;
  logic        Flush_D = 1'b0;
  logic        Branch_D = 1'b0;
  logic [31:0] IR_F = 32'h0;
  logic [31:0] PC_F = 32'h0;
  logic [31:0] PC4_F = 32'h0;
  logic [31:0] IR_D, PC_D, PC4_D, PC8_D, StallCnt, BubbleCnt;
  logic        Valid_D, BD_D;
  logic [4:0]  ExcCode_D;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_reg_fd dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Stall_D   (Stall_D),
    .Flush_D   (Flush_D),
    .Branch_D  (Branch_D),
    .IR_F      (IR_F),
    .PC_F      (PC_F),
    .PC4_F     (PC4_F),
    .IR_D      (IR_D),
    .PC_D      (PC_D),
    .PC4_D     (PC4_D),
    .PC8_D     (PC8_D),
    .Valid_D   (Valid_D),
    .BD_D      (BD_D),
    .ExcCode_D (ExcCode_D),
    .StallCnt  (StallCnt),
    .BubbleCnt (BubbleCnt)
  );

  typedef struct {
    logic        stall, flush, branch;
    logic [31:0] ir, pc;
    logic [31:0] e_ir, e_pc, e_pc4, e_pc8;
    logic        e_valid, e_bd;
    logic [4:0]  e_exc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic fl, input logic br,
                     input logic [31:0] ir, input logic [31:0] pc,
                     input logic [31:0] e_ir, input logic [31:0] e_pc,
                     input logic e_valid, input logic e_bd, input logic [4:0] e_exc);
    vec_t v;
    v.stall = st; v.flush = fl; v.branch = br; v.ir = ir; v.pc = pc;
    v.e_ir = e_ir; v.e_pc = e_pc; v.e_pc4 = e_pc + 32'd4; v.e_pc8 = e_pc + 32'd8;
    v.e_valid = e_valid; v.e_bd = e_bd; v.e_exc = e_exc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " IR_D"},      IR_D,      32'h0);
    chk({tag, " PC_D"},      PC_D,      32'h3000);
    chk({tag, " PC4_D"},     PC4_D,     32'h3004);
    chk({tag, " PC8_D"},     PC8_D,     32'h3008);
    chk({tag, " Valid_D"},   {31'd0, Valid_D}, 32'd0);
    chk({tag, " BD_D"},      {31'd0, BD_D},    32'd0);
    chk({tag, " ExcCode_D"}, {27'd0, ExcCode_D}, 32'd0);
    chk({tag, " StallCnt"},  StallCnt,  32'd0);
    chk({tag, " BubbleCnt"}, BubbleCnt, 32'd0);
  endtask

  int exp_stall_after_hold;
  int exp_bubble_final;

  initial begin
`ifdef PIPE_FD_PERF_EN
    exp_stall_after_hold = 3;
    exp_bubble_final     = 2;
`else
    exp_stall_after_hold = 0;
    exp_bubble_final     = 0;
`endif
    //  st fl br  IR_F          PC_F          exp IR        exp PC        V  BD exc
    add(0, 0, 0, 32'h3C010001, 32'h0000_3000, 32'h3C010001, 32'h0000_3000, 1, 0, 5'd0);
    add(0, 0, 0, 32'h10220003, 32'h0000_3004, 32'h10220003, 32'h0000_3004, 1, 0, 5'd0);
    add(0, 0, 1, 32'h24010005, 32'h0000_3008, 32'h24010005, 32'h0000_3008, 1, 1, 5'd0);
    add(1, 0, 0, 32'h11111111, 32'h0000_300C, 32'h24010005, 32'h0000_3008, 1, 1, 5'd0);
    add(1, 0, 1, 32'h22222222, 32'h0000_3002, 32'h24010005, 32'h0000_3008, 1, 1, 5'd0);
    add(1, 0, 0, 32'h33333333, 32'h0000_300C, 32'h24010005, 32'h0000_3008, 1, 1, 5'd0);
    add(1, 1, 1, 32'h44444444, 32'h0000_3010, 32'h00000000, 32'h0000_3010, 0, 0, 5'd0);
    add(0, 0, 1, 32'h8C220000, 32'h0000_3014, 32'h8C220000, 32'h0000_3014, 1, 0, 5'd0);
    add(0, 0, 0, 32'h12345678, 32'h0000_3002, 32'h00000000, 32'h0000_3002, 1, 0, 5'd4);
    add(0, 0, 0, 32'h12345678, 32'h0000_4000, 32'h00000000, 32'h0000_4000, 1, 0, 5'd4);
    add(0, 0, 0, 32'hAABBCCDD, 32'h0000_3FFC, 32'hAABBCCDD, 32'h0000_3FFC, 1, 0, 5'd0);
    add(0, 0, 0, 32'h55555555, 32'hFFFF_FFFC, 32'h00000000, 32'hFFFF_FFFC, 1, 0, 5'd4);
    add(0, 0, 0, 32'h66666666, 32'h0000_2FFC, 32'h00000000, 32'h0000_2FFC, 1, 0, 5'd4);
    add(0, 1, 0, 32'h77777777, 32'h0000_3020, 32'h00000000, 32'h0000_3020, 0, 0, 5'd0);

    // reset held two cycles, outputs at reset values before any load
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    chk_reset_vals("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      Stall_D  = vecs[i].stall;
      Flush_D  = vecs[i].flush;
      Branch_D = vecs[i].branch;
      IR_F     = vecs[i].ir;
      PC_F     = vecs[i].pc;
      PC4_F    = vecs[i].pc + 32'd4;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d IR_D", i),      IR_D,  vecs[i].e_ir);
      chk($sformatf("v%0d PC_D", i),      PC_D,  vecs[i].e_pc);
      chk($sformatf("v%0d PC4_D", i),     PC4_D, vecs[i].e_pc4);
      chk($sformatf("v%0d PC8_D", i),     PC8_D, vecs[i].e_pc8);
      chk($sformatf("v%0d Valid_D", i),   {31'd0, Valid_D}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d BD_D", i),      {31'd0, BD_D},    {31'd0, vecs[i].e_bd});
      chk($sformatf("v%0d ExcCode_D", i), {27'd0, ExcCode_D}, {27'd0, vecs[i].e_exc});
      if (i == 5) chk("StallCnt after hold", StallCnt, 32'(exp_stall_after_hold));
    end
    chk("BubbleCnt final", BubbleCnt, 32'(exp_bubble_final));
    chk("StallCnt final",  StallCnt,  32'(exp_stall_after_hold));

    // reset asserted mid-stall with flush pending: reset must win
    @(negedge CLK);
    Stall_D = 1'b1; Flush_D = 1'b0; Branch_D = 1'b0;
    IR_F = 32'h99999999; PC_F = 32'h0000_3100; PC4_F = 32'h0000_3104;
    @(negedge CLK);
    Flush_D = 1'b1;
    RESET   = 1'b1;
    @(posedge CLK);
    #1;
    chk_reset_vals("reset mid-stall");
    @(negedge CLK);
    RESET = 1'b0; Stall_D = 1'b0; Flush_D = 1'b0;
    chk("post-reset Valid_D", {31'd0, Valid_D}, 32'd0);
    @(posedge CLK);
    #1;
    chk("post-reset load IR_D", IR_D, 32'h99999999);
    chk("post-reset load PC8_D", PC8_D, 32'h0000_3108);
    chk("post-reset load Valid_D", {31'd0, Valid_D}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
